// File: rtl/adder_err_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_err_accum_if
// Brief    : Run control, sample pair and result bundle for adder_err_accum.
//            sum_sq exists only when ADDER_ERR_ACCUM_MSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_err_accum_if #(
    parameter int WIDTH = 17
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   exact;
    logic [WIDTH-1:0]   approx;
    logic               busy;
    logic               done;
    logic [WIDTH+31:0]  sum_ed;
    logic [WIDTH-1:0]   max_ed;
    logic [31:0]        err_cnt;
`ifdef ADDER_ERR_ACCUM_MSE_EN
    logic [2*WIDTH+31:0] sum_sq;
`endif

    modport master (
`ifdef ADDER_ERR_ACCUM_MSE_EN
        input  sum_sq,
`endif
        output start, in_valid, exact, approx,
        input  in_ready, busy, done, sum_ed, max_ed, err_cnt
    );

    modport slave (
`ifdef ADDER_ERR_ACCUM_MSE_EN
        output sum_sq,
`endif
        input  start, in_valid, exact, approx,
        output in_ready, busy, done, sum_ed, max_ed, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/adder_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : adder_err_accum
// Brief    : Accumulates |exact - approx| statistics over SAMPLES result pairs.
//            Define ADDER_ERR_ACCUM_MSE_EN to add the squared-error sum sum_sq.
// Revision : 1.0 - initial release
// ============================================================================
module adder_err_accum #(
    parameter int          WIDTH   = 17,
    parameter int unsigned SAMPLES = 65536
) (
    input  wire logic         clk,
    input  wire logic         rst,
    adder_err_accum_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [31:0] c_last = 32'(SAMPLES - 1);

    logic [1:0]         r_state;
    logic [31:0]        r_cnt;
    logic               r_s1_vld;
    logic [WIDTH-1:0]   r_ed;
    logic [WIDTH+31:0]  r_sum_ed;
    logic [WIDTH-1:0]   r_max_ed;
    logic [31:0]        r_err_cnt;

    logic               w_accept;
    logic               w_start;
    logic [WIDTH-1:0]   w_ed;

    assign w_accept = bus.in_valid && (r_state == c_st_run);
    assign w_start  = bus.start && ((r_state == c_st_idle) || (r_state == c_st_done));
    // Subtract the smaller from the larger so the distance never wraps
    assign w_ed     = (bus.exact >= bus.approx) ? (bus.exact - bus.approx)
                                                : (bus.approx - bus.exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (bus.start) begin
                        r_state <= c_st_run;
                        r_cnt   <= 32'd0;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_cnt == c_last) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_done;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_ed     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_ed <= w_ed;
            end
        end
    end

    // Stage 2 lands on the DRAIN->DONE edge, so the final beat is in the results
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_sum_ed  <= '0;
            r_max_ed  <= '0;
            r_err_cnt <= 32'd0;
        end else if (r_s1_vld) begin
            r_sum_ed <= r_sum_ed + {32'd0, r_ed};
            if (r_ed > r_max_ed) begin
                r_max_ed <= r_ed;
            end
            if (r_ed != '0) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

`ifdef ADDER_ERR_ACCUM_MSE_EN
    logic [2*WIDTH-1:0]  w_sq;
    logic [2*WIDTH+31:0] r_sum_sq;

    assign w_sq = {{WIDTH{1'b0}}, r_ed} * {{WIDTH{1'b0}}, r_ed};

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_sum_sq <= '0;
        end else if (r_s1_vld) begin
            r_sum_sq <= r_sum_sq + {32'd0, w_sq};
        end
    end

    assign bus.sum_sq = r_sum_sq;
`endif

    assign bus.in_ready = (r_state == c_st_run);
    assign bus.busy     = (r_state == c_st_run) || (r_state == c_st_drain);
    assign bus.done     = (r_state == c_st_done);
    assign bus.sum_ed   = r_sum_ed;
    assign bus.max_ed   = r_max_ed;
    assign bus.err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_err_accum
// Brief    : Directed self-checking bench for adder_err_accum (SAMPLES 4, 3, 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_err_accum;

    localparam int c_width = 17;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    adder_err_accum_if #(.WIDTH(c_width)) a4 ();
    adder_err_accum_if #(.WIDTH(c_width)) a3 ();
    adder_err_accum_if #(.WIDTH(c_width)) a1 ();

    adder_err_accum #(.WIDTH(c_width), .SAMPLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(a4));
    adder_err_accum #(.WIDTH(c_width), .SAMPLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(a3));
    adder_err_accum #(.WIDTH(c_width), .SAMPLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(a1));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [c_width-1:0] ex [4];
    logic [c_width-1:0] ap [4];
    logic [5:0]         vpat;

    initial begin
        ex[0] = 17'd100; ap[0] = 17'd100;
        ex[1] = 17'd100; ap[1] = 17'd96;
        ex[2] = 17'd96;  ap[2] = 17'd100;
        ex[3] = 17'd0;   ap[3] = 17'd65535;
        vpat  = 6'b101001;  // bit i drives cycle i: 1,0,0,1,0,1

        rst = 1'b1;
        a4.start = 1'b0; a4.in_valid = 1'b0; a4.exact = '0; a4.approx = '0;
        a3.start = 1'b0; a3.in_valid = 1'b0; a3.exact = '0; a3.approx = '0;
        a1.start = 1'b0; a1.in_valid = 1'b0; a1.exact = '0; a1.approx = '0;
        tick();
        tick();

        check("rst_in_ready", 128'(a4.in_ready), 128'(0));
        check("rst_busy",     128'(a4.busy),     128'(0));
        check("rst_done",     128'(a4.done),     128'(0));
        check("rst_sum_ed",   128'(a4.sum_ed),   128'(0));
        check("rst_max_ed",   128'(a4.max_ed),   128'(0));
        check("rst_err_cnt",  128'(a4.err_cnt),  128'(0));
        rst = 1'b0;
        tick();

        // SAMPLES=4 mixed pairs
        a4.start = 1'b1;
        tick();
        a4.start = 1'b0;
        check("a_busy",     128'(a4.busy),     128'(1));
        check("a_in_ready", 128'(a4.in_ready), 128'(1));
        for (int i = 0; i < 4; i++) begin
            a4.in_valid = 1'b1; a4.exact = ex[i]; a4.approx = ap[i];
            tick();
        end
        a4.in_valid = 1'b0;
        check("a_ready_after_last", 128'(a4.in_ready), 128'(0));
        check("a_done_early",       128'(a4.done),     128'(0));
        tick();
        check("a_done",    128'(a4.done),    128'(1));
        check("a_busy_dn", 128'(a4.busy),    128'(0));
        check("a_sum_ed",  128'(a4.sum_ed),  128'(65543));
        check("a_max_ed",  128'(a4.max_ed),  128'(65535));
        check("a_err_cnt", 128'(a4.err_cnt), 128'(3));
`ifdef ADDER_ERR_ACCUM_MSE_EN
        check("a_sum_sq",  128'(a4.sum_sq),  128'(64'd4294836257));
`endif
        tick();
        check("a_hold_sum", 128'(a4.sum_ed), 128'(65543));

        // Restart from DONE: old data must not leak into the new run
        a4.start = 1'b1;
        tick();
        a4.start = 1'b0;
        check("d_clr_sum", 128'(a4.sum_ed),  128'(0));
        check("d_clr_max", 128'(a4.max_ed),  128'(0));
        check("d_clr_cnt", 128'(a4.err_cnt), 128'(0));
        for (int i = 0; i < 4; i++) begin
            a4.in_valid = 1'b1; a4.exact = 17'd1; a4.approx = 17'd0;
            tick();
        end
        a4.in_valid = 1'b0;
        tick();
        check("d_done",    128'(a4.done),    128'(1));
        check("d_sum_ed",  128'(a4.sum_ed),  128'(4));
        check("d_max_ed",  128'(a4.max_ed),  128'(1));
        check("d_err_cnt", 128'(a4.err_cnt), 128'(4));
`ifdef ADDER_ERR_ACCUM_MSE_EN
        check("d_sum_sq",  128'(a4.sum_sq),  128'(4));
`endif

        // SAMPLES=3 with stalls
        a3.start = 1'b1;
        tick();
        a3.start = 1'b0;
        a3.exact = 17'd8; a3.approx = 17'd0;
        for (int i = 0; i < 6; i++) begin
            a3.in_valid = vpat[i];
            tick();
            if (i == 2) begin
                check("b_stall_sum", 128'(a3.sum_ed),  128'(8));
                check("b_stall_cnt", 128'(a3.err_cnt), 128'(1));
            end
        end
        a3.in_valid = 1'b0;
        check("b_ready_after_last", 128'(a3.in_ready), 128'(0));
        tick();
        check("b_done",    128'(a3.done),    128'(1));
        check("b_sum_ed",  128'(a3.sum_ed),  128'(24));
        check("b_max_ed",  128'(a3.max_ed),  128'(8));
        check("b_err_cnt", 128'(a3.err_cnt), 128'(3));

        // start held high through RUN, then reset mid-run
        a3.start = 1'b1;
        tick();
        check("c_clr_sum", 128'(a3.sum_ed),  128'(0));
        check("c_clr_cnt", 128'(a3.err_cnt), 128'(0));
        for (int i = 0; i < 2; i++) begin
            a3.in_valid = 1'b1; a3.exact = 17'd3; a3.approx = 17'd1;
            tick();
        end
        a3.in_valid = 1'b0;
        tick();
        check("c_no_restart_sum",  128'(a3.sum_ed), 128'(4));
        check("c_no_restart_busy", 128'(a3.busy),   128'(1));
        rst = 1'b1;
        a3.in_valid = 1'b1;
        tick();
        check("c_rst_busy",     128'(a3.busy),     128'(0));
        check("c_rst_in_ready", 128'(a3.in_ready), 128'(0));
        check("c_rst_done",     128'(a3.done),     128'(0));
        check("c_rst_sum",      128'(a3.sum_ed),   128'(0));
        check("c_rst_max",      128'(a3.max_ed),   128'(0));
        check("c_rst_cnt",      128'(a3.err_cnt),  128'(0));
        rst = 1'b0;
        a3.start = 1'b0; a3.in_valid = 1'b0;
        tick();
        tick();
        check("c_idle_sum", 128'(a3.sum_ed), 128'(0));
        a3.start = 1'b1;
        tick();
        a3.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a3.in_valid = 1'b1; a3.exact = 17'd5; a3.approx = 17'd5;
            tick();
        end
        a3.in_valid = 1'b0;
        tick();
        check("c_done",    128'(a3.done),    128'(1));
        check("c_sum_ed",  128'(a3.sum_ed),  128'(0));
        check("c_err_cnt", 128'(a3.err_cnt), 128'(0));
        check("c_max_ed",  128'(a3.max_ed),  128'(0));

        // SAMPLES=1 with full-scale distance
        a1.start = 1'b1;
        tick();
        a1.start = 1'b0;
        a1.in_valid = 1'b1; a1.exact = 17'd131071; a1.approx = 17'd0;
        tick();
        a1.in_valid = 1'b0;
        check("e_in_ready", 128'(a1.in_ready), 128'(0));
        check("e_done_early", 128'(a1.done),   128'(0));
        tick();
        check("e_done",    128'(a1.done),    128'(1));
        check("e_max_ed",  128'(a1.max_ed),  128'(131071));
        check("e_sum_ed",  128'(a1.sum_ed),  128'(131071));
        check("e_err_cnt", 128'(a1.err_cnt), 128'(1));
`ifdef ADDER_ERR_ACCUM_MSE_EN
        check("e_sum_sq",  128'(a1.sum_sq),  128'(64'd17179607041));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
